// File: rtl/fft_seq_ctrl_if.sv
// Handshake and data bundle between the FFT frame sequencer and its environment
// (ADC stream, sample RAM, FFT core, peak detector and CPU result port).
interface fft_seq_ctrl_if #(
  parameter int RAM_ADDR_WIDTH   = 8,
  parameter int INOUT_DATA_WIDTH = 16
);
  logic                        arm;
  logic                        continuous;
  logic                        abort;
  logic                        adc_valid;
  logic [INOUT_DATA_WIDTH-1:0] adc_data;
  logic                        smp_wen;
  logic [RAM_ADDR_WIDTH-1:0]   smp_waddr;
  logic [INOUT_DATA_WIDTH-1:0] smp_wdata;
  logic                        fft_start;
  logic                        fft_done;
  logic [RAM_ADDR_WIDTH-1:0]   peak_addr1;
  logic [RAM_ADDR_WIDTH-1:0]   peak_addr2;
  logic                        res_valid;
  logic                        res_ack;
  logic [RAM_ADDR_WIDTH-1:0]   res_max1;
  logic [RAM_ADDR_WIDTH-1:0]   res_max2;
  logic                        busy;
  logic                        timeout_err;
  logic [15:0]                 frame_cnt;

  modport master (
    input  arm, continuous, abort, adc_valid, adc_data,
    input  fft_done, peak_addr1, peak_addr2, res_ack,
    output smp_wen, smp_waddr, smp_wdata, fft_start,
    output res_valid, res_max1, res_max2, busy, timeout_err, frame_cnt
  );

  modport slave (
    output arm, continuous, abort, adc_valid, adc_data,
    output fft_done, peak_addr1, peak_addr2, res_ack,
    input  smp_wen, smp_waddr, smp_wdata, fft_start,
    input  res_valid, res_max1, res_max2, busy, timeout_err, frame_cnt
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the 256-point FFT: fills the sample RAM, starts the core,
// waits for done with a timeout and holds the two peak bins for the CPU.
module fft_seq_ctrl #(
  parameter int RAM_ADDR_WIDTH   = 8,
  parameter int INOUT_DATA_WIDTH = 16,
  parameter int DONE_TIMEOUT     = 4096
) (
  input logic             clk,
  input logic             rst_n,
  fft_seq_ctrl_if.master  bus
);

  localparam int                        TW        = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0]             TMO_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_START, S_RUN, S_CAPTURE, S_REPORT
  } state_e;

  state_e                      state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]               tmo_q, tmo_d, tmo_inc;
  logic                        done_prev_q;
  logic                        smp_wen_q, smp_wen_d;
  logic [RAM_ADDR_WIDTH-1:0]   smp_waddr_q, smp_waddr_d;
  logic [INOUT_DATA_WIDTH-1:0] smp_wdata_q, smp_wdata_d;
  logic                        fft_start_q, fft_start_d;
  logic                        res_valid_q, res_valid_d;
  logic [RAM_ADDR_WIDTH-1:0]   res_max1_q, res_max1_d;
  logic [RAM_ADDR_WIDTH-1:0]   res_max2_q, res_max2_d;
  logic                        busy_q, busy_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [15:0]                 frame_cnt_q, frame_cnt_d;

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    smp_wen_d     = 1'b0;
    smp_waddr_d   = smp_waddr_q;
    smp_wdata_d   = smp_wdata_q;
    fft_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_max1_d    = res_max1_q;
    res_max2_d    = res_max2_q;
    timeout_err_d = timeout_err_q;
    frame_cnt_d   = frame_cnt_q;

    if (bus.abort) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            state_d       = S_FILL;
            cnt_d         = '0;
            timeout_err_d = 1'b0;
          end
        end
        S_FILL: begin
          if (bus.adc_valid) begin
            smp_wen_d   = 1'b1;
            smp_waddr_d = cnt_q;
            smp_wdata_d = bus.adc_data;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = S_START;
          end
        end
        S_START: begin
          fft_start_d = 1'b1;
          tmo_d       = '0;
          state_d     = S_RUN;
        end
        S_RUN: begin
          // A completion edge in the same cycle as the timeout still counts as done.
          if (bus.fft_done && !done_prev_q) begin
            state_d = S_CAPTURE;
          end else if (tmo_inc == TMO_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        S_CAPTURE: begin
          res_max1_d  = bus.peak_addr1;
          res_max2_d  = bus.peak_addr2;
          frame_cnt_d = frame_cnt_q + 16'd1;
          res_valid_d = 1'b1;
          state_d     = S_REPORT;
        end
        S_REPORT: begin
          if (bus.res_ack) begin
            res_valid_d = 1'b0;
            if (bus.continuous) begin
              state_d = S_FILL;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // done_prev tracks the raw input every cycle, so a done level carried over
  // from an earlier frame must fall and rise again before RUN will accept it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      done_prev_q   <= 1'b0;
      smp_wen_q     <= 1'b0;
      smp_waddr_q   <= '0;
      smp_wdata_q   <= '0;
      fft_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_max1_q    <= '0;
      res_max2_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      done_prev_q   <= bus.fft_done;
      smp_wen_q     <= smp_wen_d;
      smp_waddr_q   <= smp_waddr_d;
      smp_wdata_q   <= smp_wdata_d;
      fft_start_q   <= fft_start_d;
      res_valid_q   <= res_valid_d;
      res_max1_q    <= res_max1_d;
      res_max2_q    <= res_max2_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.smp_wen     = smp_wen_q;
  assign bus.smp_waddr   = smp_waddr_q;
  assign bus.smp_wdata   = smp_wdata_q;
  assign bus.fft_start   = fft_start_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_max1    = res_max1_q;
  assign bus.res_max2    = res_max2_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl with an 8-sample frame and a 16-cycle done timeout:
// table-driven frames, hand-written corner sequences and randomized frames.
module tb_fft_seq_ctrl;
  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int TMO = 16;
  localparam int N   = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.RAM_ADDR_WIDTH(AW), .INOUT_DATA_WIDTH(DW)) bus ();

  fft_seq_ctrl #(
    .RAM_ADDR_WIDTH(AW), .INOUT_DATA_WIDTH(DW), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks     = 0;
  int n_fail       = 0;
  int start_cnt    = 0;
  int model_frames = 0;

  typedef struct {
    logic [AW-1:0] p1, p2;
    int            done_dly, ack_dly;
    logic [AW-1:0] exp_m1, exp_m2;
    logic [15:0]   exp_frames;
  } vec_t;
  vec_t vecs [4];

  always @(posedge clk) if (bus.fft_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),        0);
    chk({tag, "_wen"},       32'(bus.smp_wen),     0);
    chk({tag, "_waddr"},     32'(bus.smp_waddr),   0);
    chk({tag, "_wdata"},     32'(bus.smp_wdata),   0);
    chk({tag, "_start"},     32'(bus.fft_start),   0);
    chk({tag, "_valid"},     32'(bus.res_valid),   0);
    chk({tag, "_max1"},      32'(bus.res_max1),    0);
    chk({tag, "_max2"},      32'(bus.res_max2),    0);
    chk({tag, "_tmo_err"},   32'(bus.timeout_err), 0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt),   0);
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("busy_after_arm", 32'(bus.busy), 1);
  endtask

  // Accepts one full frame from FILL; returns two cycles into RUN.
  task automatic fill_frame(input int max_gap, input bit seq);
    logic [DW-1:0] d;
    int gap;
    for (int i = 0; i < N; i++) begin
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = 16'($urandom);
        step();
        chk("wen_in_gap", 32'(bus.smp_wen), 0);
      end
      d = seq ? 16'(i + 1) : 16'($urandom);
      bus.adc_valid = 1'b1;
      bus.adc_data  = d;
      step();
      bus.adc_valid = 1'b0;
      chk("wen",   32'(bus.smp_wen),   1);
      chk("waddr", 32'(bus.smp_waddr), 32'(i));
      chk("wdata", 32'(bus.smp_wdata), 32'(d));
    end
    chk("start_early", 32'(bus.fft_start), 0);
    bus.adc_valid = 1'b1;
    step();
    bus.adc_valid = 1'b0;
    chk("start_pulse",     32'(bus.fft_start), 1);
    chk("wen_outside_fill", 32'(bus.smp_wen),  0);
    step();
    chk("start_single", 32'(bus.fft_start), 0);
  endtask

  // From RUN: done rise, result check, then ack (or abort while reporting).
  task automatic finish_frame(input logic [AW-1:0] p1, input logic [AW-1:0] p2,
                              input int done_dly, input int ack_dly,
                              input bit cont, input bit abort_rep,
                              input logic [AW-1:0] exp_m1, input logic [AW-1:0] exp_m2);
    bus.peak_addr1 = p1;
    bus.peak_addr2 = p2;
    for (int c = 0; c < done_dly; c++) begin
      bus.fft_done = 1'b0;
      step();
      chk("valid_before_done", 32'(bus.res_valid), 0);
    end
    bus.fft_done = 1'b1;
    step();
    chk("valid_done_plus1", 32'(bus.res_valid), 0);
    chk("busy_capture",     32'(bus.busy),      1);
    bus.fft_done = 1'($urandom_range(0, 1));
    step();
    model_frames++;
    chk("valid_done_plus2", 32'(bus.res_valid), 1);
    chk("res_max1",         32'(bus.res_max1),  32'(exp_m1));
    chk("res_max2",         32'(bus.res_max2),  32'(exp_m2));
    chk("frame_cnt",        32'(bus.frame_cnt), 32'(model_frames & 32'hFFFF));
    bus.peak_addr1 = ~p1;
    bus.peak_addr2 = ~p2;
    bus.fft_done   = 1'b0;
    for (int c = 0; c < ack_dly; c++) begin
      step();
      chk("valid_held",    32'(bus.res_valid), 1);
      chk("res_max1_held", 32'(bus.res_max1),  32'(exp_m1));
    end
    if (abort_rep) begin
      bus.abort   = 1'b1;
      bus.res_ack = 1'($urandom_range(0, 1));
      step();
      bus.abort   = 1'b0;
      bus.res_ack = 1'b0;
      chk("abort_rep_valid", 32'(bus.res_valid), 0);
      chk("abort_rep_busy",  32'(bus.busy),      0);
      chk("abort_rep_max1",  32'(bus.res_max1),  32'(exp_m1));
      chk("abort_rep_max2",  32'(bus.res_max2),  32'(exp_m2));
    end else begin
      bus.res_ack    = 1'b1;
      bus.continuous = cont;
      step();
      bus.res_ack = 1'b0;
      chk("valid_after_ack", 32'(bus.res_valid), 0);
      chk("busy_after_ack",  32'(bus.busy),      32'(cont));
    end
    $display("frame %0d: max1=%0d max2=%0d cont=%0b abort=%0b",
             model_frames, bus.res_max1, bus.res_max2, cont, abort_rep);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int s0;
    bit idle;
    bit cont;
    logic [AW-1:0] rp1, rp2;

    vecs[0] = '{3'd5, 3'd2, 3, 2, 3'd5, 3'd2, 16'd1};
    vecs[1] = '{3'd7, 3'd0, 0, 0, 3'd7, 3'd0, 16'd2};
    vecs[2] = '{3'd0, 3'd7, 8, 5, 3'd0, 3'd7, 16'd3};
    vecs[3] = '{3'd1, 3'd6, 10, 1, 3'd1, 3'd6, 16'd4};

    bus.arm = 0; bus.continuous = 0; bus.abort = 0; bus.adc_valid = 0;
    bus.adc_data = 0; bus.fft_done = 0; bus.peak_addr1 = 0; bus.peak_addr2 = 0;
    bus.res_ack = 0;

    #22;
    check_all_zero("reset");
    #1 rst_n = 1'b1;
    step();

    // Table-driven single-shot frames (row 0 is the basic 0x0001..0x0008 frame).
    for (int v = 0; v < 4; v++) begin
      do_arm();
      fill_frame(3, 1'b1);
      finish_frame(vecs[v].p1, vecs[v].p2, vecs[v].done_dly, vecs[v].ack_dly,
                   1'b0, 1'b0, vecs[v].exp_m1, vecs[v].exp_m2);
      chk("table_frame_cnt", 32'(bus.frame_cnt), 32'(vecs[v].exp_frames));
      step();
      chk("table_idle_busy", 32'(bus.busy), 0);
    end

    // Continuous: three frames back to back, one start each.
    s0 = start_cnt;
    bus.continuous = 1'b1;
    do_arm();
    for (int f = 0; f < 3; f++) begin
      fill_frame(2, 1'b1);
      finish_frame(3'(f + 1), 3'(6 - f), 2, 1, (f < 2), 1'b0, 3'(f + 1), 3'(6 - f));
    end
    chk("cont_start_pulses", 32'(start_cnt - s0), 3);
    chk("cont_frame_cnt",    32'(bus.frame_cnt),  7);
    bus.continuous = 1'b0;

    // Timeout: flag appears 16 cycles after the START cycle.
    do_arm();
    fill_frame(1, 1'b1);
    for (int c = 0; c < 13; c++) step();
    chk("tmo_not_yet",   32'(bus.timeout_err), 0);
    chk("tmo_busy_run",  32'(bus.busy),        1);
    step();
    chk("tmo_flag",      32'(bus.timeout_err), 1);
    chk("tmo_idle",      32'(bus.busy),        0);
    chk("tmo_no_valid",  32'(bus.res_valid),   0);
    chk("tmo_frame_cnt", 32'(bus.frame_cnt),   32'(model_frames));
    step(); step();
    chk("tmo_sticky",    32'(bus.timeout_err), 1);
    do_arm();
    chk("tmo_cleared_by_arm", 32'(bus.timeout_err), 0);

    // Abort in FILL after three samples, then samples in IDLE are dropped.
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = 16'(16'hA0 + i);
      step();
      chk("abort_fill_waddr", 32'(bus.smp_waddr), 32'(i));
    end
    bus.adc_valid = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_fill_busy", 32'(bus.busy), 0);
    for (int c = 0; c < 12; c++) begin
      bus.adc_valid = 1'b1;
      step();
      chk("idle_drop_wen", 32'(bus.smp_wen), 0);
    end
    bus.adc_valid = 1'b0;
    chk("abort_fill_no_start", 32'(start_cnt - s0), 0);

    // Abort together with arm in IDLE.
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    chk("abort_arm_busy", 32'(bus.busy), 0);
    step();
    chk("abort_arm_busy2", 32'(bus.busy), 0);

    // Stale done held high across FILL and START.
    bus.fft_done = 1'b1;
    do_arm();
    fill_frame(1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stale_no_valid", 32'(bus.res_valid), 0);
      chk("stale_busy",     32'(bus.busy),      1);
    end
    bus.fft_done = 1'b0;
    step();
    chk("stale_fall_no_valid", 32'(bus.res_valid), 0);
    finish_frame(3'd4, 3'd3, 0, 1, 1'b0, 1'b0, 3'd4, 3'd3);

    // Abort while reporting.
    do_arm();
    fill_frame(1, 1'b0);
    finish_frame(3'd6, 3'd1, 2, 2, 1'b0, 1'b1, 3'd6, 3'd1);
    chk("abort_rep_frame_cnt", 32'(bus.frame_cnt), 32'(model_frames));

    // Randomized frames; continuous toggles mid-frame, only the ack-time value counts.
    idle = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (idle) do_arm();
      cont = (r == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.continuous = 1'($urandom_range(0, 1));
      fill_frame(3, 1'b0);
      rp1 = 3'($urandom);
      rp2 = 3'($urandom);
      bus.continuous = ~cont;
      finish_frame(rp1, rp2, $urandom_range(0, 10), $urandom_range(0, 4),
                   cont, 1'b0, rp1, rp2);
      idle = !cont;
    end
    step();
    chk("random_end_idle", 32'(bus.busy), 0);

    // Asynchronous reset in RUN.
    do_arm();
    fill_frame(1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_frames = 0;
    step();
    chk("rst_held_start", 32'(bus.fft_start), 0);
    #2 rst_n = 1'b1;
    step();
    do_arm();
    fill_frame(2, 1'b1);
    finish_frame(3'd5, 3'd2, 1, 0, 1'b0, 1'b0, 3'd5, 3'd2);
    chk("post_rst_frame_cnt", 32'(bus.frame_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
